demux_rr_dispatcher: RTL and testbench
======================================

// Module: demux_rr_dispatcher
// PURPOSE
//  Dispatches one input beat stream to NOUT destinations in round-robin bursts
//  of BURST beats. It drives the select of a 1xNOUT demux datapath and owns the
//  valid/ready handshake on every leg. A one-entry holding register decouples
//  input from output. Sits upstream of per-destination consumers.
// PARAMETERS
//  DW    8   data width, bits
//  NOUT  2   number of destinations; legal values are 2..8
//  BURST 4   beats sent per grant; legal values are >=1
//  SW    $clog2(NOUT), min 1   select width (localparam, derived)
// PORTS
//  clk       in   1        single clock, rising edge
//  rst       in   1        synchronous reset, active-high
//  en_mask   in   NOUT     per-destination enable; sampled only at arbitration
//  in_valid  in   1        input beat valid
//  in_data   in   DW       input beat
//  in_ready  out  1        input beat accepted when in_valid && in_ready
//  out_valid out  NOUT     one-hot valid per destination (demux leg)
//  out_data  out  NOUT*DW  leg k = out_data[k*DW +: DW]
//  out_ready in   NOUT     per-destination ready
//  sel       out  SW       current grant index (demux select)
//  busy      out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset
//   - All outputs reset to 0.
//   - The held beat is discarded. state=IDLE, beat_cnt=0.
//   - last_grant=NOUT-1, so the first grant goes to port 0.
//   - Reset mid-burst aborts the burst; nothing is replayed.
//  FSM: IDLE -> XFER -> DRAIN -> IDLE
//   - IDLE
//     - If in_valid && |en_mask: grant = first enabled index scanning
//       last_grant+1, +2, ... mod NOUT (wrap-around).
//     - Register sel=grant and last_grant=grant, then go to XFER.
//     - in_ready=0 in IDLE. If en_mask==0, stay in IDLE indefinitely.
//   - XFER
//     - in_ready = !hold_v || out_ready[sel].
//     - Each accept loads hold and increments beat_cnt.
//     - When the BURST-th beat is accepted: go to DRAIN and clear beat_cnt.
//   - DRAIN
//     - in_ready=0.
//     - When hold_v==0, or hold pops this cycle: go to IDLE.
//  Holding register / outputs
//   - Latency: accepted beat appears on out_data leg sel the next cycle,
//     with out_valid[sel]=1.
//   - Pop when out_valid[sel] && out_ready[sel].
//   - Pop and accept in the same cycle: hold reloads, hold_v stays 1
//     (full throughput, 1 beat/cycle).
//   - Unselected legs: out_valid=0, out_data=0.
//   - Leg data is stable while valid && !ready.
//   - out_ready of unselected legs is ignored.
//  Rules
//   - en_mask changes during XFER/DRAIN do not affect the burst in flight.
//   - sel is constant from IDLE exit until DRAIN exits.
//   - A grant to a disabled port is impossible.
//   - Single enabled port: every grant goes to that port.
//   - BURST=1: XFER lasts until exactly one accept.
// STRUCTURE
//  - Package demux_sched_pkg: state enum {IDLE, XFER, DRAIN}; function
//    clog2_min1; default DW/NOUT/BURST constants.
//  - Sub-module rr_pick (combinational): inputs mask[NOUT], last[SW];
//    outputs grant[SW], any. Instantiated once.
//  - beat_cnt width: $clog2(BURST+1).
// TESTING
//  1. Reset, mask=2'b11, continuous in_valid, in_data 0..7, all ready
//     -> beats 0-3 on leg0, beats 4-7 on leg1; sel 0 then 1.
//  2. mask=2'b10 after reset -> first grant is port 1, and every later grant
//     is port 1. mask=0 -> in_ready stays 0 and busy stays 0.
//  3. out_ready[0]=0 for 3 cycles mid-burst -> out_data leg0 held stable;
//     in_ready=0 while hold is full; no beat lost or duplicated.
//  4. en_mask flipped 11->01 during XFER on port 1 -> burst finishes on
//     port 1; next grant is port 0.
//  5. rst asserted with hold_v=1 and beat_cnt=2 -> next cycle all outputs 0,
//     busy=0; next grant is port 0.
//  6. NOUT=4, BURST=1, mask=4'b1010 -> grant sequence 1, 3, 1, 3.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the round-robin burst dispatcher.
// Latency: none (declarations only).
// Backpressure: not applicable.
package demux_sched_pkg;

  // Dispatcher control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DW    = 8;
  localparam int DEF_NOUT  = 2;
  localparam int DEF_BURST = 4;

  // Index width for n items, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_rr_dispatcher_rr_pick.sv
// Round-robin picker: first set mask bit after 'last', wrapping modulo NOUT.
// Latency: combinational.
// Backpressure: none; 'any' is low when no destination is enabled.
module rr_pick
  import demux_sched_pkg::*;
#(
  parameter int NOUT = DEF_NOUT,
  parameter int SW   = clog2_min1(NOUT)
)(
  input  logic [NOUT-1:0] mask,
  input  logic [SW-1:0]   last,
  output logic [SW-1:0]   grant,
  output logic            any
);

  int   idx;
  logic found;

  assign any = |mask;

  // Scan last+1, last+2, ... and keep the first enabled index; offset NOUT
  // revisits 'last' itself so a single enabled port always wins again.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NOUT; i++) begin
      idx = (int'(last) + i) % NOUT;
      if (!found && mask[idx]) begin
        grant = SW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Dispatches one beat stream to NOUT legs in round-robin bursts of BURST beats.
// Latency: an accepted beat appears on its leg the next cycle (1-entry hold).
// Backpressure: in_ready follows hold space / selected out_ready; full rate when ready.
module demux_rr_dispatcher
  import demux_sched_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int NOUT  = DEF_NOUT,
  parameter  int BURST = DEF_BURST,
  localparam int SW    = clog2_min1(NOUT)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [NOUT-1:0]    en_mask,
  input  logic               in_valid,
  input  logic [DW-1:0]      in_data,
  output logic               in_ready,
  output logic [NOUT-1:0]    out_valid,
  output logic [NOUT*DW-1:0] out_data,
  input  logic [NOUT-1:0]    out_ready,
  output logic [SW-1:0]      sel,
  output logic               busy
);

  localparam int            CW        = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  state_t         state;
  logic [SW-1:0]  last_grant;
  logic [CW-1:0]  beat_cnt;
  logic           hold_v;
  logic [DW-1:0]  hold_data;
  logic [SW-1:0]  pick_grant;
  logic           pick_any;
  logic           sel_ready;
  logic           accept;
  logic           pop;

  rr_pick #(
    .NOUT (NOUT),
    .SW   (SW)
  ) u_pick (
    .mask  (en_mask),
    .last  (last_grant),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // Only the granted leg's ready matters; the others are ignored.
  assign sel_ready = out_ready[sel];
  assign pop       = hold_v && sel_ready;
  assign in_ready  = (state == XFER) && (!hold_v || sel_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);

  // Burst control: grant in IDLE, count accepts in XFER, empty the hold in DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      last_grant <= SW'(NOUT - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // en_mask is only looked at here, so mid-burst changes wait for the next grant
          if (in_valid && pick_any) begin
            sel        <= pick_grant;
            last_grant <= pick_grant;
            beat_cnt   <= '0;
            state      <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (!hold_v || pop) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register: reload on accept (even while popping), clear on a bare pop
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v    <= 1'b0;
      hold_data <= '0;
    end else if (accept) begin
      hold_v    <= 1'b1;
      hold_data <= in_data;
    end else if (pop) begin
      hold_v    <= 1'b0;
    end
  end

  // Demux legs: only the selected leg carries the held beat, the rest read zero
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < NOUT; k++) begin
      if (hold_v && (sel == SW'(k))) begin
        out_valid[k]          = 1'b1;
        out_data[k*DW +: DW]  = hold_data;
      end
    end
  end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
module tb_demux_rr_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT A: NOUT=2, BURST=4
  logic [1:0]  a_mask;
  logic        a_in_valid;
  logic [7:0]  a_in_data;
  logic        a_in_ready;
  logic [1:0]  a_out_valid;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_ready;
  logic        a_sel;
  logic        a_busy;

  // DUT B: NOUT=4, BURST=1
  logic [3:0]  b_mask;
  logic        b_in_valid;
  logic [7:0]  b_in_data;
  logic        b_in_ready;
  logic [3:0]  b_out_valid;
  logic [31:0] b_out_data;
  logic [3:0]  b_out_ready;
  logic [1:0]  b_sel;
  logic        b_busy;

  int checks = 0;
  int errors = 0;
  int got_a[$];
  int got_b[$];

  demux_rr_dispatcher #(.DW(8), .NOUT(2), .BURST(4)) dut_a (
    .clk(clk), .rst(rst), .en_mask(a_mask), .in_valid(a_in_valid),
    .in_data(a_in_data), .in_ready(a_in_ready), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_ready(a_out_ready), .sel(a_sel), .busy(a_busy)
  );

  demux_rr_dispatcher #(.DW(8), .NOUT(4), .BURST(1)) dut_b (
    .clk(clk), .rst(rst), .en_mask(b_mask), .in_valid(b_in_valid),
    .in_data(b_in_data), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_ready(b_out_ready), .sel(b_sel), .busy(b_busy)
  );

  // Record every beat that pops off a leg as leg*256 + data
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++)
        if (a_out_valid[k] && a_out_ready[k]) got_a.push_back(k*256 + int'(a_out_data[k*8 +: 8]));
      for (int k = 0; k < 4; k++)
        if (b_out_valid[k] && b_out_ready[k]) got_b.push_back(k*256 + int'(b_out_data[k*8 +: 8]));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_a.delete();
    got_b.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_mask = 2'b11; a_in_valid = 1'b1; a_in_data = 8'h55; a_out_ready = 2'b11;
    b_mask = 4'hF;  b_in_valid = 1'b1; b_in_data = 8'h55; b_out_ready = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_out_valid !== 2'b00 || a_out_data !== 16'h0 || a_in_ready !== 1'b0 || a_sel !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: valid=%b data=%h ready=%b sel=%b busy=%b, want all 0",
               a_out_valid, a_out_data, a_in_ready, a_sel, a_busy);
    end
    checks++;
    if (b_out_valid !== 4'h0 || b_out_data !== 32'h0 || b_in_ready !== 1'b0 || b_sel !== 2'd0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: valid=%b data=%h ready=%b sel=%0d busy=%b, want all 0",
               b_out_valid, b_out_data, b_in_ready, b_sel, b_busy);
    end
  endtask

  task automatic test_two_port_rr();
    int idx;
    bit acc;
    a_mask = 2'b11; a_out_ready = 2'b11;
    do_reset();
    a_in_valid = 1'b1; a_in_data = 8'd0; idx = 0;
    for (int cyc = 0; cyc < 60 && got_a.size() < 8; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (a_in_ready !== 1'b0 || a_busy !== 1'b0) begin
          errors++; $display("FAIL rr_idle: in_ready=%b busy=%b, want 0 0", a_in_ready, a_busy);
        end
      end
      if (cyc == 1) begin
        checks++;
        if (a_sel !== 1'b0 || a_busy !== 1'b1 || a_in_ready !== 1'b1) begin
          errors++; $display("FAIL rr_first_grant: sel=%b busy=%b in_ready=%b, want 0 1 1", a_sel, a_busy, a_in_ready);
        end
      end
      if (cyc == 2) begin
        checks++;
        if (a_out_valid !== 2'b01 || a_out_data !== 16'h0000) begin
          errors++; $display("FAIL rr_latency: valid=%b data=%h, want 01 0000", a_out_valid, a_out_data);
        end
      end
      if (cyc == 7) begin
        checks++;
        if (a_sel !== 1'b1 || a_busy !== 1'b1) begin
          errors++; $display("FAIL rr_second_grant: sel=%b busy=%b, want 1 1", a_sel, a_busy);
        end
      end
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++; a_in_data = 8'(idx);
        if (idx == 8) a_in_valid = 1'b0;
      end
    end
    checks++;
    if (got_a.size() != 8) begin
      errors++; $display("FAIL rr_count: got %0d beats, want 8", got_a.size());
    end
    for (int i = 0; i < 8 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] != ((i < 4) ? i : 256 + i)) begin
        errors++; $display("FAIL rr_beat%0d: got leg%0d data %0d, want leg%0d data %0d",
                           i, got_a[i] / 256, got_a[i] % 256, (i < 4) ? 0 : 1, i);
      end
    end
  endtask

  task automatic test_mask_single_and_zero();
    int idx;
    bit acc;
    a_mask = 2'b10; a_out_ready = 2'b11;
    do_reset();
    a_in_valid = 1'b1; a_in_data = 8'd0; idx = 0;
    for (int cyc = 0; cyc < 80 && got_a.size() < 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        checks++;
        if (a_sel !== 1'b1) begin
          errors++; $display("FAIL single_first_grant: sel=%b, want 1", a_sel);
        end
      end
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++; a_in_data = 8'(idx);
        if (idx == 8) a_in_valid = 1'b0;
      end
    end
    checks++;
    if (got_a.size() != 8) begin
      errors++; $display("FAIL single_count: got %0d beats, want 8", got_a.size());
    end
    for (int i = 0; i < 8 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] != 256 + i) begin
        errors++; $display("FAIL single_beat%0d: got leg%0d data %0d, want leg1 data %0d",
                           i, got_a[i] / 256, got_a[i] % 256, i);
      end
    end
    a_mask = 2'b00;
    do_reset();
    a_in_valid = 1'b1; a_in_data = 8'hAA;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b0 || a_busy !== 1'b0) begin
        errors++; $display("FAIL zero_mask_c%0d: in_ready=%b busy=%b, want 0 0", cyc, a_in_ready, a_busy);
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int idx;
    bit acc;
    a_mask = 2'b11; a_out_ready = 2'b11;
    do_reset();
    a_in_valid = 1'b1; a_in_data = 8'd0; idx = 0;
    for (int cyc = 0; cyc < 80 && got_a.size() < 8; cyc++) begin
      @(negedge clk);
      if (cyc >= 3 && cyc <= 5) begin
        checks++;
        if (a_out_valid !== 2'b01 || a_out_data[7:0] !== 8'd1 || a_in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_c%0d: valid=%b leg0=%0d in_ready=%b, want 01 1 0",
                             cyc, a_out_valid, a_out_data[7:0], a_in_ready);
        end
      end
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (cyc == 2) a_out_ready[0] = 1'b0;
      if (cyc == 5) a_out_ready[0] = 1'b1;
      if (acc) begin
        idx++; a_in_data = 8'(idx);
        if (idx == 8) a_in_valid = 1'b0;
      end
    end
    checks++;
    if (got_a.size() != 8) begin
      errors++; $display("FAIL stall_count: got %0d beats, want 8", got_a.size());
    end
    for (int i = 0; i < 8 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] != ((i < 4) ? i : 256 + i)) begin
        errors++; $display("FAIL stall_beat%0d: got leg%0d data %0d, want leg%0d data %0d",
                           i, got_a[i] / 256, got_a[i] % 256, (i < 4) ? 0 : 1, i);
      end
    end
  endtask

  task automatic test_mask_change_mid_burst();
    int idx;
    bit acc;
    bit flipped;
    a_mask = 2'b11; a_out_ready = 2'b11;
    do_reset();
    a_in_valid = 1'b1; a_in_data = 8'd0; idx = 0; flipped = 1'b0;
    for (int cyc = 0; cyc < 100 && got_a.size() < 12; cyc++) begin
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (!flipped && a_busy && a_sel == 1'b1) begin
        a_mask = 2'b01; flipped = 1'b1;
      end
      if (acc) begin
        idx++; a_in_data = 8'(idx);
        if (idx == 12) a_in_valid = 1'b0;
      end
    end
    checks++;
    if (got_a.size() != 12) begin
      errors++; $display("FAIL flip_count: got %0d beats, want 12", got_a.size());
    end
    for (int i = 0; i < 12 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] != ((i >= 4 && i < 8) ? 256 + i : i)) begin
        errors++; $display("FAIL flip_beat%0d: got leg%0d data %0d, want leg%0d data %0d",
                           i, got_a[i] / 256, got_a[i] % 256, (i >= 4 && i < 8) ? 1 : 0, i);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int idx;
    bit acc;
    a_mask = 2'b11; a_out_ready = 2'b11;
    do_reset();
    a_in_valid = 1'b1; a_in_data = 8'd0; idx = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++; a_in_data = 8'(idx);
      end
      if (cyc == 2) rst = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (a_out_valid !== 2'b01 || a_out_data[7:0] !== 8'd1 || a_busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_state: valid=%b leg0=%0d busy=%b, want 01 1 1",
                         a_out_valid, a_out_data[7:0], a_busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    got_a.delete();
    a_in_valid = 1'b1; a_in_data = 8'h40; idx = 0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 2'b00 || a_out_data !== 16'h0 || a_in_ready !== 1'b0 || a_sel !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL post_reset: valid=%b data=%h ready=%b sel=%b busy=%b, want all 0",
                         a_out_valid, a_out_data, a_in_ready, a_sel, a_busy);
    end
    acc = a_in_valid && a_in_ready;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40 && (a_busy || a_in_valid); cyc++) begin
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++; a_in_data = 8'(8'h40 + idx);
        if (idx == 4) a_in_valid = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    checks++;
    if (got_a.size() != 4) begin
      errors++; $display("FAIL post_reset_count: got %0d beats, want 4", got_a.size());
    end
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] != 'h40 + i) begin
        errors++; $display("FAIL post_reset_beat%0d: got leg%0d data %0d, want leg0 data %0d",
                           i, got_a[i] / 256, got_a[i] % 256, 'h40 + i);
      end
    end
  endtask

  task automatic test_four_port_burst1();
    int idx;
    bit acc;
    int exp_b[4];
    exp_b[0] = 256 + 0; exp_b[1] = 768 + 1; exp_b[2] = 256 + 2; exp_b[3] = 768 + 3;
    b_mask = 4'b1010; b_out_ready = 4'hF;
    do_reset();
    b_in_valid = 1'b1; b_in_data = 8'd0; idx = 0;
    for (int cyc = 0; cyc < 40 && got_b.size() < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        checks++;
        if (b_sel !== 2'd1) begin
          errors++; $display("FAIL b_sel_first: sel=%0d, want 1", b_sel);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (b_sel !== 2'd3) begin
          errors++; $display("FAIL b_sel_second: sel=%0d, want 3", b_sel);
        end
      end
      acc = b_in_valid && b_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++; b_in_data = 8'(idx);
        if (idx == 4) b_in_valid = 1'b0;
      end
    end
    checks++;
    if (got_b.size() != 4) begin
      errors++; $display("FAIL b_count: got %0d beats, want 4", got_b.size());
    end
    for (int i = 0; i < 4 && i < got_b.size(); i++) begin
      checks++;
      if (got_b[i] != exp_b[i]) begin
        errors++; $display("FAIL b_beat%0d: got leg%0d data %0d, want leg%0d data %0d",
                           i, got_b[i] / 256, got_b[i] % 256, exp_b[i] / 256, exp_b[i] % 256);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_port_rr();
    test_mask_single_and_zero();
    test_backpressure();
    test_mask_change_mid_burst();
    test_reset_mid_burst();
    test_four_port_burst1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
